// File: rtl/jtframe_rom_arb.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_rom_arb
// Purpose  : Shares one SDRAM read port among four ROM requesters. Each
//            requester (slot) owns a one-entry cache (address, data, valid).
//            A hit is answered combinationally. A miss is arbitrated
//            round-robin and turned into a single SDRAM request/ack/data
//            handshake whose result refills that slot's cache entry.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_rom      in   1        sole clock, rising edge
//   rst_n        in   1        synchronous active-low reset
//   downloading  in   1        ROM download active: flush caches, no grants
//   slot_cs      in   SLOTS    per-slot read request level
//   slot_addr    in   SLOTS*AW per-slot word address, slot i at [i*AW +: AW]
//   slot_ok      out  SLOTS    per-slot data valid (cache hit)
//   slot_dout    out  SLOTS*DW per-slot cached data, slot i at [i*DW +: DW]
//   sdram_req    out  1        request to the SDRAM controller
//   sdram_ack    in   1        controller accepted the request (pulse)
//   sdram_addr   out  AW       address of the outstanding request
//   data_read    in   DW       read data from the controller
//   data_rdy     in   1        data_read valid (pulse)
//   busy         out  1        arbiter FSM is not idle
// ============================================================================
module jtframe_rom_arb #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
) (
  input  logic                clk_rom,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [AW-1:0]       sdram_addr,
  input  logic [DW-1:0]       data_read,
  input  logic                data_rdy,
  output logic                busy
);

  // Slot index width. SLOTS is a power of two, so index arithmetic wraps
  // naturally and gives the modulo needed by the round-robin search.
  localparam int IW = $clog2(SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_t;

  state_t state, state_nx;

  // Per-slot cache entries
  logic [AW-1:0]    cache_addr [SLOTS];
  logic [DW-1:0]    cache_data [SLOTS];
  logic [SLOTS-1:0] valid;

  // Arbitration bookkeeping
  logic [IW-1:0]    cur;
  logic [IW-1:0]    last_grant;

  // Combinational decode
  logic [AW-1:0]    slot_addr_a [SLOTS];
  logic [SLOTS-1:0] hit;
  logic [SLOTS-1:0] pending;
  logic [IW:0]      pick;
  logic             grant_found;
  logic [IW-1:0]    grant_idx;

  // FSM control strobes
  logic             grant_en;
  logic             ack_en;
  logic             fill_en;

  // --------------------------------------------------------------------------
  // Per-slot hit / pending decode and output mapping
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      assign slot_addr_a[i]           = slot_addr[i*AW +: AW];
      assign hit[i]                   = slot_cs[i] & valid[i] &
                                        (slot_addr_a[i] == cache_addr[i]);
      assign pending[i]               = slot_cs[i] & ~hit[i] & ~downloading;
      assign slot_ok[i]               = hit[i];
      assign slot_dout[i*DW +: DW]    = cache_data[i];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin pick: search starts one past the last granted slot. Walking
  // the offsets from farthest to nearest lets the nearest pending slot
  // overwrite any farther one. Returns {found, index}.
  // --------------------------------------------------------------------------
  function automatic logic [IW:0] rr_pick(input logic [SLOTS-1:0] pend,
                                          input logic [IW-1:0]    last);
    logic [IW:0]   r;
    logic [IW-1:0] c;
    r = '0;
    for (int k = SLOTS; k >= 1; k--) begin
      c = last + IW'(k);
      if (pend[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  assign pick        = rr_pick(pending, last_grant);
  assign grant_found = pick[IW];
  assign grant_idx   = pick[IW-1:0];

  assign busy        = (state != ST_IDLE);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_rom) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // --------------------------------------------------------------------------
  // FSM next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    grant_en = 1'b0;
    ack_en   = 1'b0;
    fill_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        // downloading is already folded into pending, so no grant here
        if (grant_found) begin
          grant_en = 1'b1;
          state_nx = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) begin
          ack_en = 1'b1;
          // A controller that returns data together with the ack must not
          // leave us waiting for a data_rdy that already went by.
          if (data_rdy) begin
            fill_en  = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (data_rdy) begin
          fill_en  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request, arbitration and cache datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      cur        <= '0;
      last_grant <= IW'(SLOTS - 1);   // slot 0 is searched first
      valid      <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        cache_addr[i] <= '0;
        cache_data[i] <= '0;
      end
    end else begin
      if (grant_en) begin
        cur        <= grant_idx;
        last_grant <= grant_idx;
        // Latched once here and held until the transfer ends, so a
        // requester changing its address cannot disturb the handshake.
        sdram_addr <= slot_addr_a[grant_idx];
        sdram_req  <= 1'b1;
      end

      if (ack_en) sdram_req <= 1'b0;

      // The entry is tagged with the address actually fetched; if the slot
      // has moved on, the tag mismatch keeps slot_ok low and re-requests.
      if (fill_en) begin
        cache_data[cur] <= data_read;
        cache_addr[cur] <= sdram_addr;
      end

      // During a download every entry is stale, including one being filled.
      if (downloading)  valid      <= '0;
      else if (fill_en) valid[cur] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/jtframe_rom_arb.md
JTFRAME_ROM_ARB -- requirements
Module: jtframe_rom_arb

Interface
REQ-001 Parameter SLOTS, default 4, number of ROM requesters; fixed at 4 in this revision.
REQ-002 Parameter AW, default 22, SDRAM word-address width.
REQ-003 Parameter DW, default 32, SDRAM read-data width.
REQ-004 clk_rom  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 downloading  in  1  ROM download in progress; blocks new SDRAM requests.
REQ-007 slot_cs  in  4  per-slot read request level; bit i belongs to slot i.
REQ-008 slot_addr  in  4*AW  per-slot word address; slot i at bits [i*AW +: AW].
REQ-009 slot_ok  out  4  per-slot data-valid flag.
REQ-010 slot_dout  out  4*DW  per-slot cached data; slot i at bits [i*DW +: DW].
REQ-011 sdram_req  out  1  request to the SDRAM controller.
REQ-012 sdram_ack  in  1  controller accepted the request (one-cycle pulse).
REQ-013 sdram_addr  out  AW  address of the current request.
REQ-014 data_read  in  DW  read data from the controller.
REQ-015 data_rdy  in  1  data_read valid (one-cycle pulse).
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 Each slot SHALL own a cache entry: cache_addr[AW], cache_data[DW], valid bit.
REQ-018 hit[i] SHALL be slot_cs[i] & valid[i] & (slot_addr[i]==cache_addr[i]), decoded combinationally.
REQ-019 slot_ok[i] SHALL equal hit[i]; slot_dout[i] SHALL equal cache_data[i] at all times.
REQ-020 pending[i] SHALL be slot_cs[i] & ~hit[i] & ~downloading.
REQ-021 The FSM SHALL have the states IDLE, WAIT_ACK and WAIT_DATA.
REQ-022 IDLE with any pending bit set SHALL grant one slot by round-robin: search starts at last_grant+1 modulo 4, first pending slot wins.
REQ-023 On grant the block SHALL, at the next edge: latch the slot index into cur and last_grant; latch slot_addr[cur] into sdram_addr; set sdram_req=1; enter WAIT_ACK.
REQ-024 WAIT_ACK with sdram_ack=1 SHALL clear sdram_req at the next edge and enter WAIT_DATA.
REQ-025 If sdram_ack and data_rdy are both high in WAIT_ACK, the block SHALL take the WAIT_DATA completion in the same cycle and go to IDLE.
REQ-026 WAIT_DATA with data_rdy=1 SHALL write data_read into cache_data[cur] and sdram_addr into cache_addr[cur], set valid[cur] (unless REQ-029 applies), and return to IDLE.
REQ-027 Minimum grant-to-grant spacing SHALL be one IDLE cycle. Hit latency is 0 cycles (slot_ok is combinational); miss latency is controller latency plus 2 cycles.
REQ-028 A slot_addr change during the slot's own transfer SHALL NOT abort it; the entry is filled with the latched address, and slot_ok stays low until the address matches.
REQ-029 downloading=1 SHALL clear all valid bits every cycle and block new grants. An in-flight transfer SHALL complete its handshake, but its valid bit is not set.
REQ-030 slot_cs falling SHALL drop slot_ok the same cycle and SHALL NOT cancel an in-flight transfer.
REQ-031 sdram_addr SHALL hold stable from sdram_req rising until data_rdy.
REQ-032 At most one SDRAM request SHALL be outstanding at any time.

Reset
REQ-033 While rst_n=0 at an edge, the block SHALL force: state=IDLE, sdram_req=0, sdram_addr=0, all valid=0, cache_addr=0, cache_data=0, cur=0, last_grant=3 (slot 0 first in the search).
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer. A data_rdy arriving after reset release in IDLE SHALL be ignored.
REQ-035 All outputs SHALL be 0 during reset: slot_ok=0, slot_dout=0, busy=0.

Verification
REQ-036 Single miss: slot1 cs=1, addr=0x00100; controller ack after 2 cycles, data_rdy after 3 more with data 0xDEADBEEF -> sdram_req 1 then 0, slot_ok[1]=1, slot_dout[1]=0xDEADBEEF; a repeat read causes no new sdram_req.
REQ-037 Round-robin: all 4 slots miss simultaneously after reset -> grants in order 0,1,2,3; then slots 2 and 0 miss again -> order 0,2.
REQ-038 Simultaneous ack+data_rdy in one cycle -> cache filled, FSM back in IDLE next cycle, no stuck sdram_req.
REQ-039 Download: fill slot0; raise downloading during a slot3 transfer -> slot_ok[0] drops at once, slot3 handshake completes with valid[3]=0, no sdram_req while downloading=1.
REQ-040 Address change mid-transfer: slot2 requests 0x3FFFFF then switches to 0x000000 before data_rdy -> entry holds 0x3FFFFF, slot_ok[2]=0, new request for 0x000000 issued next.
REQ-041 Reset mid-operation: rst_n=0 in WAIT_DATA -> all outputs 0; a later stray data_rdy leaves every valid bit at 0.
